// File: rtl/ring_output_scheduler.sv
// ring_output_scheduler
// Per-output-port scheduler for the ring router. Each cycle it picks the
// oldest eligible packet from the transit (high) or local (low) slot array
// and launches it on the registered link output. A starvation counter forces
// a local grant after STARVE_LIMIT consecutive transit grants while local waits.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clk_counter     global cycle counter, used to compute packet age
//   backpressure    1 = downstream cannot accept this cycle
//   buf_high/low    flattened slot arrays, slot i at [i*PACKET_SIZE +: PACKET_SIZE]
//   route_high/low  2-bit route code per slot
//   out_packet      registered link output, all-zero when idle
//   grant_valid     registered one-cycle pulse per launched packet
//   grant_pos       slot index of the launched packet
//   grant_high      1 = launched slot is in buf_high
//   starve_cnt      current starvation count
module ring_output_scheduler #(
    parameter int unsigned PACKET_SIZE  = 49,
    parameter int unsigned BUFFER_SIZE  = 4,
    parameter int unsigned PTR_LEN      = $clog2(BUFFER_SIZE),
    parameter logic [1:0]  OUT_PORT     = 2'b01,
    parameter int unsigned STARVE_LIMIT = 4,
    localparam int unsigned SC_W        = (STARVE_LIMIT == 0) ? 1 : $clog2(STARVE_LIMIT + 1)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [15:0]                        clk_counter,
    input  logic                               backpressure,
    input  logic [BUFFER_SIZE*PACKET_SIZE-1:0] buf_high,
    input  logic [BUFFER_SIZE*2-1:0]           route_high,
    input  logic [BUFFER_SIZE*PACKET_SIZE-1:0] buf_low,
    input  logic [BUFFER_SIZE*2-1:0]           route_low,
    output logic [PACKET_SIZE-1:0]             out_packet,
    output logic                               grant_valid,
    output logic [PTR_LEN-1:0]                 grant_pos,
    output logic                               grant_high,
    output logic [SC_W-1:0]                    starve_cnt
);

    localparam int unsigned BUS_W     = BUFFER_SIZE * PACKET_SIZE;
    localparam int unsigned ROUTE_W   = BUFFER_SIZE * 2;
    localparam int unsigned VALID_BIT = PACKET_SIZE - 1;
    localparam int unsigned TS_LSB    = PACKET_SIZE - 17;
    localparam logic [SC_W-1:0] LIMIT = SC_W'(STARVE_LIMIT);

    // Oldest eligible slot of one buffer: returns {found, index}.
    // Strict '>' keeps the lowest index on equal ages.
    function automatic logic [PTR_LEN:0] oldest_slot(
        input logic [BUS_W-1:0]   slots,
        input logic [ROUTE_W-1:0] routes,
        input logic [15:0]        now,
        input logic               mask_en,
        input logic [PTR_LEN-1:0] mask_pos
    );
        logic               found;
        logic [PTR_LEN-1:0] idx;
        logic [15:0]        best_age;
        logic [15:0]        age;
        logic               elig;
        found    = 1'b0;
        idx      = '0;
        best_age = '0;
        for (int i = 0; i < int'(BUFFER_SIZE); i++) begin
            age  = now - slots[i*PACKET_SIZE + TS_LSB +: 16];
            elig = slots[i*PACKET_SIZE + VALID_BIT]
                && (routes[i*2 +: 2] == OUT_PORT)
                && !(mask_en && (mask_pos == PTR_LEN'(i)));
            if (elig && (!found || (age > best_age))) begin
                found    = 1'b1;
                idx      = PTR_LEN'(i);
                best_age = age;
            end
        end
        return {found, idx};
    endfunction

    logic [PTR_LEN:0]     h_win_c;
    logic [PTR_LEN:0]     l_win_c;
    logic                 h_ok_c;
    logic                 l_ok_c;
    logic [PTR_LEN-1:0]   h_idx_c;
    logic [PTR_LEN-1:0]   l_idx_c;
    logic                 pick_high_c;
    logic                 pick_low_c;
    logic [PACKET_SIZE-1:0] sel_pkt_c;
    logic [SC_W-1:0]      cnt_nxt_c;

    // Per-buffer winners; the slot granted last cycle is masked until cleared.
    always_comb begin
        h_win_c = oldest_slot(buf_high, route_high, clk_counter,
                              grant_valid && grant_high, grant_pos);
        l_win_c = oldest_slot(buf_low, route_low, clk_counter,
                              grant_valid && !grant_high, grant_pos);
        h_ok_c  = h_win_c[PTR_LEN];
        l_ok_c  = l_win_c[PTR_LEN];
        h_idx_c = h_win_c[PTR_LEN-1:0];
        l_idx_c = l_win_c[PTR_LEN-1:0];
    end

    // Pick rule, selected packet and next starvation count.
    always_comb begin
        pick_high_c = 1'b0;
        pick_low_c  = 1'b0;
        sel_pkt_c   = '0;
        cnt_nxt_c   = starve_cnt;

        if (h_ok_c && (!l_ok_c || (STARVE_LIMIT == 0) || (starve_cnt < LIMIT))) begin
            pick_high_c = 1'b1;
        end else if (l_ok_c) begin
            pick_low_c = 1'b1;
        end

        if (pick_high_c) begin
            sel_pkt_c = buf_high[32'(h_idx_c)*PACKET_SIZE +: PACKET_SIZE];
        end else if (pick_low_c) begin
            sel_pkt_c = buf_low[32'(l_idx_c)*PACKET_SIZE +: PACKET_SIZE];
        end

        // Count only transit grants that bypassed a waiting local packet.
        if (!backpressure) begin
            if (pick_high_c && l_ok_c) begin
                cnt_nxt_c = (starve_cnt < LIMIT) ? (starve_cnt + SC_W'(1)) : starve_cnt;
            end else begin
                cnt_nxt_c = '0;
            end
        end
    end

    // Registered link output and grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_packet  <= '0;
            grant_valid <= 1'b0;
            grant_pos   <= '0;
            grant_high  <= 1'b0;
            starve_cnt  <= '0;
        end else begin
            starve_cnt <= cnt_nxt_c;
            if (!backpressure && (pick_high_c || pick_low_c)) begin
                out_packet  <= sel_pkt_c;
                grant_valid <= 1'b1;
                grant_pos   <= pick_high_c ? h_idx_c : l_idx_c;
                grant_high  <= pick_high_c;
            end else begin
                out_packet  <= '0;
                grant_valid <= 1'b0;
                grant_pos   <= '0;
                grant_high  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ring_output_scheduler.sv
// Self-checking bench for ring_output_scheduler: directed scenarios followed
// by randomized traffic, compared each cycle against a behavioural model.
module tb_ring_output_scheduler;

    localparam int PS    = 49;
    localparam int BS    = 4;
    localparam int PL    = 2;
    localparam int LIMIT = 4;
    localparam int SCW   = 3;
    localparam logic [1:0] OUT = 2'b01;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [15:0]       clk_counter = '0;
    logic              backpressure = 1'b0;
    logic [BS*PS-1:0]  buf_high;
    logic [BS*2-1:0]   route_high;
    logic [BS*PS-1:0]  buf_low;
    logic [BS*2-1:0]   route_low;
    logic [PS-1:0]     out_packet;
    logic              grant_valid;
    logic [PL-1:0]     grant_pos;
    logic              grant_high;
    logic [SCW-1:0]    starve_cnt;

    logic [PS-1:0] hp [BS];
    logic [PS-1:0] lp [BS];
    logic [1:0]    hr [BS];
    logic [1:0]    lr [BS];

    int errors = 0;
    int checks = 0;

    // Model registers
    logic          m_gv;
    int            m_gp;
    logic          m_gh;
    int            m_cnt;
    logic [PS-1:0] m_pkt;

    ring_output_scheduler #(
        .PACKET_SIZE(PS), .BUFFER_SIZE(BS), .OUT_PORT(OUT), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clk_counter(clk_counter), .backpressure(backpressure),
        .buf_high(buf_high), .route_high(route_high), .buf_low(buf_low), .route_low(route_low),
        .out_packet(out_packet), .grant_valid(grant_valid), .grant_pos(grant_pos),
        .grant_high(grant_high), .starve_cnt(starve_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < BS; i++) begin
            buf_high[i*PS +: PS] = hp[i];
            buf_low[i*PS +: PS]  = lp[i];
            route_high[i*2 +: 2] = hr[i];
            route_low[i*2 +: 2]  = lr[i];
        end
    end

    function automatic logic [PS-1:0] mkpkt(input logic [15:0] ts, input logic [15:0] src,
                                            input logic [15:0] dst);
        return {1'b1, ts, src, dst};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_slots();
        for (int i = 0; i < BS; i++) begin
            hp[i] = '0; lp[i] = '0; hr[i] = 2'b00; lr[i] = 2'b00;
        end
    endtask

    task automatic model_reset();
        m_gv = 1'b0; m_gp = 0; m_gh = 1'b0; m_cnt = 0; m_pkt = '0;
    endtask

    // Oldest eligible slot index per the age rule, -1 if none.
    function automatic int oldest(input logic is_high);
        int best; int best_age; int age;
        logic [PS-1:0] p; logic [1:0] r;
        best = -1; best_age = -1;
        for (int i = 0; i < BS; i++) begin
            p = is_high ? hp[i] : lp[i];
            r = is_high ? hr[i] : lr[i];
            if (p[PS-1] && r == OUT && !(m_gv && m_gh == is_high && m_gp == i)) begin
                age = (int'(clk_counter) - int'(p[47:32]) + 65536) % 65536;
                if (age > best_age) begin best = i; best_age = age; end
            end
        end
        return best;
    endfunction

    // Advance one clock: predict from current inputs, clock, compare, commit.
    task automatic step(input string tag);
        int h; int l;
        logic e_gv; int e_gp; logic e_gh; int e_cnt; logic [PS-1:0] e_pkt;
        h = oldest(1'b1);
        l = oldest(1'b0);
        e_gv = 1'b0; e_gp = 0; e_gh = 1'b0; e_pkt = '0; e_cnt = m_cnt;
        if (!backpressure) begin
            if (h >= 0 && (l < 0 || m_cnt < LIMIT)) begin
                e_gv = 1'b1; e_gh = 1'b1; e_gp = h; e_pkt = hp[h];
                e_cnt = (l >= 0) ? ((m_cnt < LIMIT) ? m_cnt + 1 : m_cnt) : 0;
            end else if (l >= 0) begin
                e_gv = 1'b1; e_gh = 1'b0; e_gp = l; e_pkt = lp[l]; e_cnt = 0;
            end else begin
                e_cnt = 0;
            end
        end
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, 64'(grant_valid), 64'(e_gv));
        chk({tag, ".pkt"}, 64'(out_packet), 64'(e_pkt));
        chk({tag, ".cnt"}, 64'(starve_cnt), 64'(e_cnt));
        if (e_gv) begin
            chk({tag, ".pos"}, 64'(grant_pos), 64'(e_gp));
            chk({tag, ".high"}, 64'(grant_high), 64'(e_gh));
        end
        m_gv = e_gv; m_gp = e_gp; m_gh = e_gh; m_cnt = e_cnt; m_pkt = e_pkt;
    endtask

    task automatic rand_slot(input logic is_high, input int i);
        logic [PS-1:0] p;
        p = mkpkt(16'(clk_counter - 16'($urandom_range(0, 12))), 16'($urandom), 16'($urandom));
        if ($urandom_range(0, 9) == 0) p[PS-1] = 1'b0;
        if (is_high) begin hp[i] = p; hr[i] = 2'($urandom_range(0, 3)); end
        else         begin lp[i] = p; lr[i] = 2'($urandom_range(0, 3)); end
    endtask

    initial begin
        int exp_h [10];
        int exp_c [10];
        exp_h = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        exp_c = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};

        clear_slots();
        model_reset();

        // Reset held with an eligible slot present
        hp[0] = mkpkt(16'h0000, 16'h1111, 16'h2222); hr[0] = OUT;
        clk_counter = 16'h0010;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.valid", 64'(grant_valid), 64'd0);
        chk("reset.pkt", 64'(out_packet), 64'd0);
        chk("reset.cnt", 64'(starve_cnt), 64'd0);
        rst_n = 1'b1;
        step("first");
        chk("first.grant", 64'({grant_valid, grant_high, grant_pos}), 64'({1'b1, 1'b1, 2'd0}));
        step("masked");
        chk("masked.idle", 64'(grant_valid), 64'd0);

        // Age order with mask on the following cycle
        clear_slots();
        hp[1] = mkpkt(16'h0010, 16'h0001, 16'h0002); hr[1] = OUT;
        hp[3] = mkpkt(16'h0005, 16'h0003, 16'h0004); hr[3] = OUT;
        clk_counter = 16'h0020;
        step("age1");
        chk("age1.pos", 64'({grant_high, grant_pos}), 64'({1'b1, 2'd3}));
        step("age2");
        chk("age2.pos", 64'({grant_high, grant_pos}), 64'({1'b1, 2'd1}));

        // Timestamp wrap
        clear_slots();
        step("idle1");
        hp[0] = mkpkt(16'hFFF0, 16'h0A0A, 16'h0B0B); hr[0] = OUT;
        hp[1] = mkpkt(16'h0001, 16'h0C0C, 16'h0D0D); hr[1] = OUT;
        clk_counter = 16'h0003;
        step("wrap");
        chk("wrap.pos", 64'({grant_valid, grant_pos}), 64'({1'b1, 2'd0}));

        // Starvation: two transit and two local slots permanently eligible
        clear_slots();
        step("idle2");
        clk_counter = 16'h0100;
        hp[0] = mkpkt(16'h0001, 16'h0001, 16'h0001); hr[0] = OUT;
        hp[1] = mkpkt(16'h0002, 16'h0002, 16'h0002); hr[1] = OUT;
        lp[0] = mkpkt(16'h0003, 16'h0003, 16'h0003); lr[0] = OUT;
        lp[2] = mkpkt(16'h0004, 16'h0004, 16'h0004); lr[2] = OUT;
        for (int k = 0; k < 10; k++) begin
            step("starve");
            chk("starve.high", 64'(grant_high), 64'(exp_h[k]));
            chk("starve.cnt", 64'(starve_cnt), 64'(exp_c[k]));
        end

        // Backpressure holds count and suppresses output
        step("pre_bp");
        chk("pre_bp.cnt", 64'(starve_cnt), 64'd1);
        backpressure = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step("bp");
            chk("bp.out", 64'({grant_valid, out_packet}), 64'd0);
            chk("bp.cnt", 64'(starve_cnt), 64'd1);
        end
        backpressure = 1'b0;
        step("post_bp");
        chk("post_bp.grant", 64'({grant_valid, grant_high, grant_pos}), 64'({1'b1, 1'b1, 2'd0}));
        chk("post_bp.cnt", 64'(starve_cnt), 64'd2);

        // Route filter
        clear_slots();
        hp[0] = mkpkt(16'h0100, 16'h1, 16'h2); hr[0] = 2'b00;
        hp[1] = mkpkt(16'h0100, 16'h3, 16'h4); hr[1] = 2'b10;
        hp[2] = mkpkt(16'h0100, 16'h5, 16'h6); hp[2][PS-1] = 1'b0; hr[2] = OUT;
        lp[2] = mkpkt(16'h0100, 16'h7, 16'h8); lr[2] = 2'b00;
        lp[3] = mkpkt(16'h0100, 16'h9, 16'hA); lr[3] = 2'b10;
        step("route1");
        chk("route1.none", 64'(grant_valid), 64'd0);
        step("route2");
        chk("route2.none", 64'(grant_valid), 64'd0);
        lp[1] = mkpkt(16'h00F0, 16'hBEEF, 16'hCAFE); lr[1] = OUT;
        step("route3");
        chk("route3.grant", 64'({grant_valid, grant_high, grant_pos}), 64'({1'b1, 1'b0, 2'd1}));
        chk("route3.pkt", 64'(out_packet), 64'({1'b1, 16'h00F0, 16'hBEEF, 16'hCAFE}));

        // Randomized traffic across counter wrap
        clear_slots();
        clk_counter = 16'hFF80;
        for (int i = 0; i < BS; i++) begin rand_slot(1'b1, i); rand_slot(1'b0, i); end
        for (int n = 0; n < 400; n++) begin
            if (m_gv && $urandom_range(0, 1) == 1) begin
                if (m_gh) hp[m_gp] = '0; else lp[m_gp] = '0;
            end
            for (int i = 0; i < BS; i++) begin
                if (!hp[i][PS-1] && $urandom_range(0, 2) == 0) rand_slot(1'b1, i);
                if (!lp[i][PS-1] && $urandom_range(0, 2) == 0) rand_slot(1'b0, i);
            end
            backpressure = ($urandom_range(0, 4) == 0);
            clk_counter = clk_counter + 16'd1;
            step("rand");
        end
        backpressure = 1'b0;

        // Asynchronous reset mid-operation
        for (int i = 0; i < BS; i++) begin
            hp[i] = mkpkt(clk_counter, 16'h1, 16'h2); hr[i] = OUT;
        end
        step("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.out", 64'({grant_valid, grant_high, grant_pos, out_packet}), 64'd0);
        chk("async_rst.cnt", 64'(starve_cnt), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ring_output_scheduler.md
Name: ring_output_scheduler

Overview:
- Per-output-port scheduler for the ring router. One instance per outgoing link (east, west).
- Each cycle it picks one packet from two slot arrays: a high-priority transit buffer (the input buffer of the same direction) and a low-priority local injection buffer.
- Selection is oldest-first, gated by downstream backpressure, with a starvation guard for local traffic.
- It drives the registered link output and returns a one-cycle grant, which the router uses to clear the sent slot.

Parameters:
- PACKET_SIZE, 49, packet width. Bit PACKET_SIZE-1 is VALID, [47:32] timestamp, [31:16] source, [15:0] destination.
- BUFFER_SIZE, 4, slots per buffer (power of 2, at least 2).
- PTR_LEN, $clog2(BUFFER_SIZE), slot index width.
- OUT_PORT, 2'b01, 2-bit route code served by this instance (01 east, 10 west; 00 is eject).
- STARVE_LIMIT, 4, consecutive transit grants allowed while local waits. 0 means strict transit priority.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clk_counter  in  16  global cycle counter, used for age
- backpressure  in  1  1 = downstream cannot accept this cycle
- buf_high  in  BUFFER_SIZE*PACKET_SIZE  transit slots, flattened, slot i at [i*PACKET_SIZE +: PACKET_SIZE]
- route_high  in  BUFFER_SIZE*2  route code per transit slot
- buf_low  in  BUFFER_SIZE*PACKET_SIZE  local slots, flattened
- route_low  in  BUFFER_SIZE*2  route code per local slot
- out_packet  out  PACKET_SIZE  registered link output; all-zero when idle
- grant_valid  out  1  registered; a packet was launched this cycle
- grant_pos  out  PTR_LEN  slot index of the launched packet
- grant_high  out  1  1 = slot is in buf_high, 0 = buf_low
- starve_cnt  out  $clog2(STARVE_LIMIT+1) (min 1)  current starvation count (debug/stats)

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low. Reset drives out_packet=0, grant_valid=0, grant_pos=0, grant_high=0, starve_cnt=0. Reset mid-operation drops any in-flight selection. The first evaluation occurs on the first rising edge after deassertion.
- Eligibility: slot i is eligible when VALID=1 AND route==OUT_PORT AND it is not the slot granted last cycle. A slot is "granted last cycle" when grant_valid=1, grant_pos==i and grant_high matches its buffer. This mask covers the one cycle before the router clears the slot and prevents duplicate launch.
- Age: age = clk_counter - timestamp, 16-bit modular (wraps naturally). Larger age is older. Equal ages: the lowest index wins.
- Per-buffer winners: the oldest eligible high slot (Hwin) and the oldest eligible low slot (Lwin), found combinationally.
- Pick rule: if Hwin exists and (no Lwin, or STARVE_LIMIT==0, or starve_cnt<STARVE_LIMIT), pick Hwin; else if Lwin exists, pick Lwin; else idle.
- Output timing: registered, one-cycle latency. Decision made in cycle N appears on out_packet/grant_* in cycle N+1. grant_valid is a one-cycle pulse per launched packet.
- Backpressure=1 in cycle N:
  - the next outputs are out_packet=0 and grant_valid=0;
  - starve_cnt holds;
  - no slot is consumed;
  - the mask of a grant already registered in cycle N still applies in cycle N.
- Idle (no eligible slot, backpressure=0): out_packet=0, grant_valid=0, starve_cnt resets to 0.
- starve_cnt update (only when backpressure=0):
  - increments (saturating at STARVE_LIMIT) when Hwin is granted while Lwin exists;
  - resets to 0 when a low slot is granted, or when no Lwin exists.
- Forced local grant: when starve_cnt==STARVE_LIMIT (STARVE_LIMIT>0) and both winners exist, Lwin is granted and the counter returns to 0.
- Routing guard: slots with route 00 (eject) or the other direction are never selected. Invalid slots are ignored regardless of route bits.
- Output format: out_packet carries the selected slot unmodified, VALID bit included.

Test Plan:
- Reset: hold rst_n=0 with valid eligible slots -> all outputs 0. Release -> first grant appears the cycle after the first edge.
- Age order: high slots 1 and 3 eligible, ts=0x0010 and 0x0005, clk_counter=0x0020 -> grant_pos=3, grant_high=1. Next cycle slot 3 is masked, so with it still present grant_pos=1.
- Wrap: clk_counter=0x0003, slot0 ts=0xFFF0 (age 19), slot1 ts=0x0001 (age 2) -> slot0 granted.
- Starvation: high and low both permanently eligible, STARVE_LIMIT=4 -> sequence H,H,H,H,L,H,H,H,H,L; starve_cnt goes 1,2,3,4,0.
- Backpressure: assert backpressure for 3 cycles with eligible slots -> out_packet=0, grant_valid=0, starve_cnt unchanged. After deassert -> oldest slot granted next cycle.
- Route filter: only slots with route 00 or the other direction valid -> no grant. A single low slot with route=OUT_PORT -> grant_high=0, out_packet equals the slot contents.
